key_event_decoder: RTL

KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

---
 rtl/key_pkg.sv | 29 ++
 rtl/key_event_decoder.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the key event decoder: one-hot FSM state encodings,
// default timing constants (50 MHz clock) and a small helper used to size
// the shared cycle counter.
package key_pkg;

    // Default hold/repeat/double-click windows in clock cycles at 50 MHz.
    localparam int unsigned LONG_CNT_DEF   = 50_000_000;
    localparam int unsigned REPEAT_CNT_DEF = 10_000_000;
    localparam int unsigned DCLK_WIN_DEF   = 15_000_000;

    // One-hot state encodings; any other bit pattern is illegal.
    typedef enum logic [4:0] {
        ST_IDLE     = 5'b00001,
        ST_PRESSED  = 5'b00010,
        ST_HELD     = 5'b00100,
        ST_WAIT2    = 5'b01000,
        ST_PRESSED2 = 5'b10000
    } key_state_t;

    // Largest of three counts, used to size the shared counter.
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_event_decoder.sv
// Key event decoder: classifies debounced key edges into short click,
// long press, auto-repeat and double-click pulses.
//
// Ports:
//   clk          - system clock, rising edge
//   reset_n      - asynchronous active-low reset
//   key_flag     - one-cycle strobe marking a debounced edge
//   key_state    - debounced level when key_flag=1 (0 pressed, 1 released)
//   short_press  - one-cycle pulse, single short click
//   long_press   - one-cycle pulse, hold reached LONG_CNT
//   repeat_pulse - one-cycle pulse every REPEAT_CNT cycles while long-held
//   double_click - one-cycle pulse, second click inside DCLK_WIN
//   key_busy     - high whenever the FSM is not idle
module key_event_decoder
    import key_pkg::*;
#(
    parameter int unsigned LONG_CNT   = LONG_CNT_DEF,
    parameter int unsigned REPEAT_CNT = REPEAT_CNT_DEF,
    parameter int unsigned DCLK_WIN   = DCLK_WIN_DEF,
    parameter bit          DCLK_EN    = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_flag,
    input  logic key_state,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic double_click,
    output logic key_busy
);

    localparam int unsigned MAX_CNT = max3(LONG_CNT, REPEAT_CNT, DCLK_WIN);
    localparam int unsigned CNT_W   = $clog2(MAX_CNT);

    localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] REP_TERM  = CNT_W'(REPEAT_CNT - 1);
    localparam logic [CNT_W-1:0] DCLK_TERM = CNT_W'(DCLK_WIN - 1);

    key_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             press_evt;
    logic             release_evt;

    // An unknown key_state evaluates to X here, which no branch treats as true.
    assign press_evt   = key_flag && !key_state;
    assign release_evt = key_flag &&  key_state;

    // FSM, shared counter and registered outputs. Key events are checked
    // before count terminals so an event in the terminal cycle wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            repeat_pulse <= 1'b0;
            double_click <= 1'b0;
            key_busy     <= 1'b0;
        end else begin
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            repeat_pulse <= 1'b0;
            double_click <= 1'b0;

            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (press_evt) begin
                        state    <= ST_PRESSED;
                        key_busy <= 1'b1;
                    end
                end

                ST_PRESSED: begin
                    if (release_evt) begin
                        cnt <= '0;
                        if (DCLK_EN) begin
                            state <= ST_WAIT2;
                        end else begin
                            state       <= ST_IDLE;
                            short_press <= 1'b1;
                            key_busy    <= 1'b0;
                        end
                    end else if (cnt == LONG_TERM) begin
                        cnt        <= '0;
                        state      <= ST_HELD;
                        long_press <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Counter wraps on each repeat without leaving HELD.
                ST_HELD: begin
                    if (release_evt) begin
                        cnt      <= '0;
                        state    <= ST_IDLE;
                        key_busy <= 1'b0;
                    end else if (cnt == REP_TERM) begin
                        cnt          <= '0;
                        repeat_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_WAIT2: begin
                    if (press_evt) begin
                        cnt   <= '0;
                        state <= ST_PRESSED2;
                    end else if (cnt == DCLK_TERM) begin
                        cnt         <= '0;
                        state       <= ST_IDLE;
                        short_press <= 1'b1;
                        key_busy    <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // A long hold on the second press drops the pending first click.
                ST_PRESSED2: begin
                    if (release_evt) begin
                        cnt          <= '0;
                        state        <= ST_IDLE;
                        double_click <= 1'b1;
                        key_busy     <= 1'b0;
                    end else if (cnt == LONG_TERM) begin
                        cnt        <= '0;
                        state      <= ST_HELD;
                        long_press <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Illegal encoding: recover to IDLE silently.
                default: begin
                    cnt      <= '0;
                    state    <= ST_IDLE;
                    key_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
